// File: rtl/imul_pkg.sv
// Shared types for the iterative integer multiplier: RISC-V M product modes
// and the control FSM state encoding.
package imul_pkg;

    typedef enum logic [1:0] {
        IMUL_MUL    = 2'd0,
        IMUL_MULH   = 2'd1,
        IMUL_MULHSU = 2'd2,
        IMUL_MULHU  = 2'd3
    } imul_mode_e;

    typedef enum logic [1:0] {
        IMUL_ITER_IDLE = 2'd0,
        IMUL_ITER_CALC = 2'd1,
        IMUL_ITER_DONE = 2'd2
    } imul_iter_state_e;

endpackage

// File: rtl/imul_int_mul_iter_dpath.sv
// Shift-add datapath: operand magnitude/sign preparation, one partial product
// per step, and final sign restore plus low/high half select.
module imul_int_mul_iter_dpath
    import imul_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             add,
    input  logic             fin,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  imul_mode_e       mode,
    output logic             count_done,
    output logic             b_lsb,
    output logic [NBITS-1:0] msg
);

    localparam int CW = $clog2(NBITS) + 1;
    localparam int W2 = 2 * NBITS;

    // Magnitude of v when it is treated as signed and negative; the most
    // negative value maps onto its unsigned magnitude 2^(N-1).
    function automatic logic [NBITS-1:0] abs_if(input logic [NBITS-1:0] v, input logic en);
        if (en && v[NBITS-1]) begin
            return ~v + NBITS'(1'b1);
        end else begin
            return v;
        end
    endfunction

    logic [W2-1:0]    a_r;
    logic [NBITS-1:0] b_r;
    logic [W2-1:0]    result_r;
    logic [CW-1:0]    count_r;
    logic             neg_r;
    imul_mode_e       mode_r;
    logic [NBITS-1:0] msg_r;
    logic             sa_s;
    logic             sb_s;
    logic [W2-1:0]    p_s;

    // Operand signedness from the requested mode and the signed full product.
    always_comb begin
        sa_s = (mode == IMUL_MULH) || (mode == IMUL_MULHSU);
        sb_s = (mode == IMUL_MULH);
        if (neg_r) begin
            p_s = ~result_r + W2'(1'b1);
        end else begin
            p_s = result_r;
        end
    end

    // Operand load at accept, then one shift-add iteration per step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            count_r  <= '0;
            neg_r    <= 1'b0;
            mode_r   <= IMUL_MUL;
        end else if (load) begin
            a_r      <= {{NBITS{1'b0}}, abs_if(a, sa_s)};
            b_r      <= abs_if(b, sb_s);
            result_r <= '0;
            count_r  <= '0;
            neg_r    <= (sa_s & a[NBITS-1]) ^ (sb_s & b[NBITS-1]);
            mode_r   <= mode;
        end else if (step) begin
            if (add) begin
                result_r <= result_r + a_r;
            end
            a_r     <= a_r << 1;
            b_r     <= b_r >> 1;
            count_r <= count_r + CW'(1'b1);
        end
    end

    // Response register; recomputed from stable state so it holds under backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msg_r <= '0;
        end else if (fin) begin
            msg_r <= (mode_r == IMUL_MUL) ? p_s[NBITS-1:0] : p_s[W2-1:NBITS];
        end
    end

    assign count_done = (count_r == CW'(NBITS - 1));
    assign b_lsb      = b_r[0];
    assign msg        = msg_r;

endmodule

// File: rtl/imul_int_mul_iter.sv
// Iterative shift-add multiplier with val/rdy request and response interfaces;
// control FSM here, arithmetic in imul_int_mul_iter_dpath.
module imul_int_mul_iter
    import imul_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [NBITS-1:0] req_a,
    input  logic [NBITS-1:0] req_b,
    input  logic [1:0]       req_mode,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_msg
);

    imul_iter_state_e state_r;
    imul_iter_state_e state_next_s;
    logic             req_rdy_r;
    logic             resp_val_r;
    logic             load_s;
    logic             step_s;
    logic             add_s;
    logic             fin_s;
    logic             resp_go_s;
    logic             count_done_s;
    logic             b_lsb_s;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IMUL_ITER_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        add_s        = 1'b0;
        fin_s        = 1'b0;
        resp_go_s    = resp_val_r && resp_rdy;
        case (state_r)
            IMUL_ITER_IDLE: begin
                if (req_val && req_rdy_r) begin
                    state_next_s = IMUL_ITER_CALC;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IMUL_ITER_IDLE;
                end
            end
            IMUL_ITER_CALC: begin
                step_s = 1'b1;
                add_s  = b_lsb_s;
                if (count_done_s) begin
                    state_next_s = IMUL_ITER_DONE;
                end else begin
                    state_next_s = IMUL_ITER_CALC;
                end
            end
            IMUL_ITER_DONE: begin
                fin_s = 1'b1;
                if (resp_go_s) begin
                    state_next_s = IMUL_ITER_IDLE;
                end else begin
                    state_next_s = IMUL_ITER_DONE;
                end
            end
            default: begin
                state_next_s = IMUL_ITER_IDLE;
            end
        endcase
    end

    // Handshake flags registered so neither depends combinationally on req_* or resp_rdy;
    // resp_val rises the cycle after DONE is entered, once resp_msg is loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_rdy_r  <= 1'b0;
            resp_val_r <= 1'b0;
        end else begin
            req_rdy_r  <= (state_next_s == IMUL_ITER_IDLE);
            resp_val_r <= (state_r == IMUL_ITER_DONE) && !resp_go_s;
        end
    end

    imul_int_mul_iter_dpath #(
        .NBITS(NBITS)
    ) u_dpath (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .step       (step_s),
        .add        (add_s),
        .fin        (fin_s),
        .a          (req_a),
        .b          (req_b),
        .mode       (imul_mode_e'(req_mode)),
        .count_done (count_done_s),
        .b_lsb      (b_lsb_s),
        .msg        (resp_msg)
    );

    assign req_rdy  = req_rdy_r;
    assign resp_val = resp_val_r;

endmodule

// File: tb/tb_imul_int_mul_iter.sv
// Self-checking bench for imul_int_mul_iter: directed corner cases on a 32-bit
// instance plus randomized traffic on 32/16/8-bit instances against a product model.
module tb_imul_int_mul_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val, req_rdy, resp_val, resp_rdy;
    logic [31:0] req_a, req_b, resp_msg;
    logic [1:0]  req_mode;

    logic        s_req_val, s_resp_rdy;
    logic [1:0]  s_mode;
    logic [31:0] s_a, s_b;
    logic        r8_req_rdy, r8_resp_val, r16_req_rdy, r16_resp_val;
    logic [7:0]  r8_msg;
    logic [15:0] r16_msg;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    imul_int_mul_iter #(.NBITS(32)) dut32 (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
        .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg));

    imul_int_mul_iter #(.NBITS(16)) dut16 (
        .clk(clk), .reset(reset), .req_val(s_req_val), .req_rdy(r16_req_rdy),
        .req_a(s_a[15:0]), .req_b(s_b[15:0]), .req_mode(s_mode),
        .resp_val(r16_resp_val), .resp_rdy(s_resp_rdy), .resp_msg(r16_msg));

    imul_int_mul_iter #(.NBITS(8)) dut8 (
        .clk(clk), .reset(reset), .req_val(s_req_val), .req_rdy(r8_req_rdy),
        .req_a(s_a[7:0]), .req_b(s_b[7:0]), .req_mode(s_mode),
        .resp_val(r8_resp_val), .resp_rdy(s_resp_rdy), .resp_msg(r8_msg));

    // Reference: extend each n-bit operand to a signed integer per mode, multiply, pick a half.
    function automatic logic [31:0] ref_mul(input int n, input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] m);
        logic [63:0] mask, ua, ub, pr;
        longint      va, vb;
        mask = (64'd1 << n) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        va   = longint'(ua);
        vb   = longint'(ub);
        if ((m == 2'd1 || m == 2'd2) && ua[n-1]) va = va - longint'(64'd1 << n);
        if (m == 2'd1 && ub[n-1]) vb = vb - longint'(64'd1 << n);
        pr = 64'(va * vb);
        if (m == 2'd0) return 32'(pr & mask);
        return 32'((pr >> n) & mask);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the 32-bit instance.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                         input int rdy_dly, input bit junk,
                         output logic [31:0] msg, output int lat, output bit to);
        int k;
        to = 1'b0;
        k  = 0;
        while (!req_rdy && k < 100) begin tick(); k++; end
        if (!req_rdy) to = 1'b1;
        req_val = 1'b1; req_a = a; req_b = b; req_mode = m;
        tick();
        req_val = 1'b0;
        lat = 0;
        while (!resp_val && lat < 200) begin
            if (junk) begin
                req_val = 1'($urandom_range(0, 1));
                req_a = $urandom; req_b = $urandom; req_mode = 2'($urandom_range(0, 3));
            end
            tick();
            lat++;
        end
        req_val = 1'b0;
        if (!resp_val) to = 1'b1;
        for (int j = 0; j < rdy_dly; j++) tick();
        msg = resp_msg;
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_val = 1'b0; resp_rdy = 1'b0; req_a = '0; req_b = '0; req_mode = '0;
        s_req_val = 1'b0; s_resp_rdy = 1'b0; s_a = '0; s_b = '0; s_mode = '0;
        #1 reset = 1'b0;
        #1;
        nchk++; if (req_rdy !== 1'b0) begin nerr++; $display("FAIL reset_req_rdy got=%b exp=0", req_rdy); end
        nchk++; if (resp_val !== 1'b0) begin nerr++; $display("FAIL reset_resp_val got=%b exp=0", resp_val); end
        nchk++; if (resp_msg !== 32'd0) begin nerr++; $display("FAIL reset_resp_msg got=%h exp=0", resp_msg); end
        repeat (3) tick();
        nchk++; if (req_rdy !== 1'b0) begin nerr++; $display("FAIL reset_held_rdy got=%b exp=0", req_rdy); end
        reset = 1'b1;
        tick();
        nchk++; if (req_rdy !== 1'b1) begin nerr++; $display("FAIL release_req_rdy got=%b exp=1", req_rdy); end
    endtask

    task automatic test_basic();
        logic [31:0] msg; int lat; bit to;
        do_op(32'd3, 32'd4, 2'd0, 0, 1'b0, msg, lat, to);
        nchk++; if (to) begin nerr++; $display("FAIL basic_timeout got=1 exp=0"); end
        nchk++; if (msg !== 32'h0000000C) begin nerr++; $display("FAIL basic_msg got=%h exp=0000000c", msg); end
        nchk++; if (lat !== 33) begin nerr++; $display("FAIL basic_latency got=%0d exp=33", lat); end
        nchk++; if (req_rdy !== 1'b1) begin nerr++; $display("FAIL basic_rdy_after got=%b exp=1", req_rdy); end
    endtask

    task automatic test_corners();
        logic [31:0] ta [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'h80000000};
        logic [31:0] tb [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003, 32'h80000000, 32'h80000000};
        logic [1:0]  tm [6] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0};
        logic [31:0] te [6] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'h00000000};
        logic [31:0] msg; int lat; bit to;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], tm[i], 0, 1'b0, msg, lat, to);
            nchk++;
            if (to || msg !== te[i]) begin
                nerr++; $display("FAIL corner%0d got=%h exp=%h timeout=%0d", i, msg, te[i], to);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] msg; int lat; bit to;
        int k;
        req_val = 1'b1; req_a = 32'd7; req_b = 32'd6; req_mode = 2'd0;
        tick();
        req_val = 1'b0;
        k = 0;
        while (!resp_val && k < 200) begin tick(); k++; end
        nchk++; if (!resp_val) begin nerr++; $display("FAIL bp_timeout got=0 exp=1"); end
        req_val = 1'b1; req_a = 32'd9; req_b = 32'd9; req_mode = 2'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nchk++;
            if (resp_val !== 1'b1 || resp_msg !== 32'h2A || req_rdy !== 1'b0) begin
                nerr++; $display("FAIL bp_hold%0d got val=%b msg=%h rdy=%b exp val=1 msg=2a rdy=0",
                                 i, resp_val, resp_msg, req_rdy);
            end
        end
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        nchk++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
            nerr++; $display("FAIL bp_handshake got val=%b rdy=%b exp val=0 rdy=1", resp_val, req_rdy);
        end
        tick();
        req_val = 1'b0;
        nchk++; if (req_rdy !== 1'b0) begin nerr++; $display("FAIL bp_accept got rdy=%b exp=0", req_rdy); end
        lat = 0;
        while (!resp_val && lat < 200) begin tick(); lat++; end
        msg = resp_msg;
        resp_rdy = 1'b1; tick(); resp_rdy = 1'b0;
        nchk++; if (msg !== 32'd81) begin nerr++; $display("FAIL bp_new_op got=%h exp=00000051", msg); end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] msg; int lat; bit to; bit seen;
        req_val = 1'b1; req_a = 32'd5; req_b = 32'd5; req_mode = 2'd0;
        tick();
        req_val = 1'b0;
        repeat (10) tick();
        #3 reset = 1'b0;
        #1;
        nchk++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b0) begin
            nerr++; $display("FAIL midreset_now got val=%b rdy=%b exp val=0 rdy=0", resp_val, req_rdy);
        end
        repeat (2) tick();
        reset = 1'b1;
        resp_rdy = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin tick(); if (resp_val) seen = 1'b1; end
        resp_rdy = 1'b0;
        nchk++; if (seen) begin nerr++; $display("FAIL midreset_noresp got=1 exp=0"); end
        do_op(32'd7, 32'd6, 2'd0, 0, 1'b0, msg, lat, to);
        nchk++; if (to || msg !== 32'h2A) begin nerr++; $display("FAIL midreset_after got=%h exp=0000002a", msg); end
    endtask

    task automatic test_random32();
        logic [31:0] a, b, msg, exp;
        logic [1:0]  m;
        int lat; bit to;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom; m = 2'($urandom_range(0, 3));
            if (i % 16 == 0) a = 32'h80000000;
            if (i % 23 == 0) b = 32'hFFFFFFFF;
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            do_op(a, b, m, $urandom_range(0, 3), 1'($urandom_range(0, 1)), msg, lat, to);
            exp = ref_mul(32, a, b, m);
            nchk++;
            if (to || msg !== exp) begin
                nerr++; $display("FAIL rand32_%0d a=%h b=%h mode=%0d got=%h exp=%h timeout=%0d", i, a, b, m, msg, exp, to);
            end
        end
    endtask

    task automatic test_small_widths();
        logic [31:0] e8, e16;
        int k;
        for (int i = 0; i < 300; i++) begin
            s_a = $urandom; s_b = $urandom; s_mode = 2'($urandom_range(0, 3));
            k = 0;
            while (!(r8_req_rdy && r16_req_rdy) && k < 50) begin tick(); k++; end
            s_req_val = 1'b1;
            tick();
            s_req_val = 1'b0;
            k = 0;
            while (!(r8_resp_val && r16_resp_val) && k < 100) begin tick(); k++; end
            e8  = ref_mul(8, s_a, s_b, s_mode);
            e16 = ref_mul(16, s_a, s_b, s_mode);
            nchk++;
            if (!r8_resp_val || r8_msg !== e8[7:0]) begin
                nerr++; $display("FAIL rand8_%0d a=%h b=%h mode=%0d got=%h exp=%h", i, s_a[7:0], s_b[7:0], s_mode, r8_msg, e8[7:0]);
            end
            nchk++;
            if (!r16_resp_val || r16_msg !== e16[15:0]) begin
                nerr++; $display("FAIL rand16_%0d a=%h b=%h mode=%0d got=%h exp=%h", i, s_a[15:0], s_b[15:0], s_mode, r16_msg, e16[15:0]);
            end
            s_resp_rdy = 1'b1;
            tick();
            s_resp_rdy = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid_calc();
        test_random32();
        test_small_widths();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
